// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate data cache
// with full-line refill and writeback over the downstream trinity bus.
// Optional macro DCACHE_PERF_CNT_EN adds hit/miss/writeback counters.
module dcache_nway #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned TAG_WIDTH  = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tbus_index_valid,
  output logic        tbus_index_ready,
  input  logic [63:0] tbus_index,
  input  logic [63:0] tbus_write_data,
  input  logic [63:0] tbus_write_mask,
  input  logic [1:0]  tbus_operation_type,
  output logic [63:0] tbus_read_data,
  output logic        tbus_operation_done,
  output logic        dcache2arb_tbus_index_valid,
  input  logic        dcache2arb_tbus_index_ready,
  output logic [63:0] dcache2arb_tbus_index,
  output logic [63:0] dcache2arb_tbus_write_data,
  output logic [63:0] dcache2arb_tbus_write_mask,
  output logic [1:0]  dcache2arb_tbus_operation_type,
  input  logic [63:0] dcache2arb_tbus_read_data,
  input  logic        dcache2arb_tbus_operation_done
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt,
  output logic [31:0] perf_wb_cnt
`endif
);
  localparam int unsigned WO = $clog2(LINE_WORDS);
  localparam int unsigned SO = $clog2(SETS);
  localparam int unsigned CW = (WO > 0) ? WO : 1;
  localparam int unsigned SW = (SO > 0) ? SO : 1;
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [1:0]    OP_READ  = 2'b01;
  localparam logic [1:0]    OP_WRITE = 2'b10;
  localparam logic [CW-1:0] LAST     = CW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_RF_REQ, S_RF_WAIT, S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [63:0]            addr_q, wdata_q, wmask_q;
  logic [1:0]             op_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WW-1:0]          way_q, way_d;
  logic [TAG_WIDTH-1:0]   tag_q   [SETS][WAYS];
  logic [63:0]            data_q  [SETS][WAYS][LINE_WORDS];
  logic [WAYS-1:0]        valid_q [SETS];
  logic [WAYS-1:0]        dirty_q [SETS];
  logic [WW-1:0]          rr_q    [SETS];
  logic                   ready_q, ready_d, done_q, done_d;
  logic [63:0]            rdata_q, rdata_d;
  logic                   ds_valid_q, ds_valid_d;
  logic [63:0]            ds_index_q, ds_index_d, ds_wdata_q, ds_wdata_d, ds_wmask_q, ds_wmask_d;
  logic [1:0]             ds_op_q, ds_op_d;
  logic [CW-1:0]          req_word;
  logic [SW-1:0]          req_set;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   hit, has_inv, alloc, fill_we, fill_last, resp_we;
  logic                   hit_ev, miss_ev, wb_ev;
  logic [WW-1:0]          hit_way, inv_way, victim;

  assign req_word = CW'((addr_q >> 3) & 64'(LINE_WORDS - 1));
  assign req_set  = SW'((addr_q >> (3 + WO)) & 64'(SETS - 1));
  assign req_tag  = TAG_WIDTH'(addr_q >> (3 + WO + SO));

  function automatic logic [63:0] line_addr(input logic [TAG_WIDTH-1:0] t,
                                            input logic [SW-1:0] s, input logic [CW-1:0] w);
    return (64'(t) << (3 + WO + SO)) | (64'(s) << (3 + WO)) | (64'(w) << 3);
  endfunction

  // Tag match (lowest way wins) and victim choice: lowest invalid way, else round-robin.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[req_set][w]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
    victim = has_inv ? inv_way : rr_q[req_set];
  end

  // Next-state, array-update strobes and registered-output next values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    way_d     = way_q;
    rdata_d   = rdata_q;
    alloc     = 1'b0;
    fill_we   = 1'b0;
    fill_last = 1'b0;
    resp_we   = 1'b0;
    hit_ev    = 1'b0;
    miss_ev   = 1'b0;
    wb_ev     = 1'b0;
    case (state_q)
      S_IDLE: if (tbus_index_valid && ready_q) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (op_q != OP_READ && op_q != OP_WRITE) begin
          state_d = S_RESP;
          rdata_d = '0;
        end else if (hit) begin
          hit_ev  = 1'b1;
          state_d = S_RESP;
          way_d   = hit_way;
          rdata_d = (op_q == OP_READ) ? data_q[req_set][hit_way][req_word] : '0;
        end else begin
          miss_ev = 1'b1;
          alloc   = 1'b1;
          way_d   = victim;
          cnt_d   = '0;
          if (valid_q[req_set][victim] && dirty_q[req_set][victim]) begin
            wb_ev   = 1'b1;
            state_d = S_WB_REQ;
          end else begin
            state_d = S_RF_REQ;
          end
        end
      end
      S_WB_REQ: if (dcache2arb_tbus_index_ready) state_d = S_WB_WAIT;
      S_WB_WAIT: begin
        if (dcache2arb_tbus_operation_done) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_RF_REQ;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_WB_REQ;
          end
        end
      end
      S_RF_REQ: if (dcache2arb_tbus_index_ready) state_d = S_RF_WAIT;
      S_RF_WAIT: begin
        if (dcache2arb_tbus_operation_done) begin
          fill_we = 1'b1;
          if (cnt_q == LAST) begin
            fill_last = 1'b1;
            state_d   = S_RESP;
            if (op_q == OP_READ)
              rdata_d = (req_word == cnt_q) ? dcache2arb_tbus_read_data
                                            : data_q[req_set][way_q][req_word];
            else
              rdata_d = '0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_RF_REQ;
          end
        end
      end
      S_RESP: begin
        resp_we = (op_q == OP_WRITE);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d    = (state_d == S_IDLE);
    done_d     = (state_d == S_RESP);
    ds_valid_d = 1'b0;
    ds_op_d    = '0;
    ds_index_d = '0;
    ds_wdata_d = '0;
    ds_wmask_d = '0;
    if (state_d == S_WB_REQ) begin
      ds_valid_d = 1'b1;
      ds_op_d    = OP_WRITE;
      ds_index_d = line_addr(tag_q[req_set][way_d], req_set, cnt_d);
      ds_wdata_d = data_q[req_set][way_d][cnt_d];
      ds_wmask_d = '1;
    end else if (state_d == S_RF_REQ) begin
      ds_valid_d = 1'b1;
      ds_op_d    = OP_READ;
      ds_index_d = line_addr(req_tag, req_set, cnt_d);
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      way_q      <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      ds_valid_q <= 1'b0;
      ds_op_q    <= '0;
      ds_index_q <= '0;
      ds_wdata_q <= '0;
      ds_wmask_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      way_q      <= way_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      ds_valid_q <= ds_valid_d;
      ds_op_q    <= ds_op_d;
      ds_index_q <= ds_index_d;
      ds_wdata_q <= ds_wdata_d;
      ds_wmask_q <= ds_wmask_d;
    end
  end

  // Request latch, captured only on the acceptance cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      op_q    <= '0;
    end else if (state_q == S_IDLE && tbus_index_valid && ready_q) begin
      addr_q  <= tbus_index;
      wdata_q <= tbus_write_data;
      wmask_q <= tbus_write_mask;
      op_q    <= tbus_operation_type;
    end
  end

  // Valid, dirty and round-robin replacement state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (alloc)
        rr_q[req_set] <= (rr_q[req_set] == WW'(WAYS - 1)) ? '0 : rr_q[req_set] + WW'(1);
      if (fill_last) begin
        valid_q[req_set][way_q] <= 1'b1;
        dirty_q[req_set][way_q] <= 1'b0;
      end
      if (resp_we) dirty_q[req_set][way_q] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (fill_we) data_q[req_set][way_q][cnt_q] <= dcache2arb_tbus_read_data;
    if (resp_we)
      data_q[req_set][way_q][req_word] <= (data_q[req_set][way_q][req_word] & ~wmask_q) |
                                          (wdata_q & wmask_q);
    if (fill_last) tag_q[req_set][way_q] <= req_tag;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  // Event counters; reserved-type requests never raise an event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_ev)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_ev) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_ev)   wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
  assign perf_wb_cnt   = wb_cnt_q;
`endif

  assign tbus_index_ready               = ready_q;
  assign tbus_operation_done            = done_q;
  assign tbus_read_data                 = rdata_q;
  assign dcache2arb_tbus_index_valid    = ds_valid_q;
  assign dcache2arb_tbus_index          = ds_index_q;
  assign dcache2arb_tbus_write_data     = ds_wdata_q;
  assign dcache2arb_tbus_write_mask     = ds_wmask_q;
  assign dcache2arb_tbus_operation_type = ds_op_q;
endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised successor of the 2-way dcache: N-way set-associative, write-back, write-allocate data cache with full-line (multi-word) refill and writeback.
- Sits between the LSU trinity bus (upstream) and the DDR arbiter trinity bus (downstream).
- One request in flight on each side.
- Tag, valid and dirty bits, data and replacement state are held in internal register arrays.

Parameters:
- WAYS, 2, associativity; power of 2, range 1..8.
- SETS, 16, sets; power of 2.
- LINE_WORDS, 8, 64-bit words per line; power of 2.
- TAG_WIDTH, 20, stored tag bits.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- tbus_index_valid  in  1  upstream request valid.
- tbus_index_ready  out  1  upstream ready.
- tbus_index  in  64  byte address.
- tbus_write_data  in  64  store data.
- tbus_write_mask  in  64  per-bit store mask.
- tbus_operation_type  in  2  01=READ, 10=WRITE, 00/11 reserved.
- tbus_read_data  out  64  load data, valid only with done.
- tbus_operation_done  out  1  one-cycle completion pulse.
- dcache2arb_tbus_index_valid  out  1  downstream request valid.
- dcache2arb_tbus_index_ready  in  1  downstream ready.
- dcache2arb_tbus_index  out  64  word address.
- dcache2arb_tbus_write_data  out  64  writeback data.
- dcache2arb_tbus_write_mask  out  64  writeback mask; all ones on writes.
- dcache2arb_tbus_operation_type  out  2  01/10.
- dcache2arb_tbus_read_data  in  64  refill data.
- dcache2arb_tbus_operation_done  in  1  downstream completion pulse.

Behaviour:
- Address split:
  - word = addr[3+WO-1:3], WO = log2(LINE_WORDS).
  - set = next log2(SETS) bits.
  - tag = next TAG_WIDTH bits.
  - addr[2:0] ignored.
- Reset:
  - All outputs 0; state IDLE.
  - All valid/dirty bits, round-robin pointers and counters cleared.
  - Data array is not reset.
  - Reset mid-operation aborts the request. Downstream valid drops asynchronously and no upstream done is issued. Dirty data is lost.
- Upstream handshake:
  - ready = 1 only in IDLE.
  - Request is accepted on valid & ready; address, data, mask and type are latched.
  - Inputs are ignored outside the acceptance cycle.
- States:
  - IDLE: on accept, go to LOOKUP.
  - LOOKUP:
    - Reserved type: go to RESP, no state change, data 0.
    - Hit: go to RESP.
    - Miss: select victim.
      - Victim is the lowest-index invalid way; if all ways are valid, the per-set round-robin pointer (pointer increments mod WAYS on each allocation).
      - Victim valid & dirty: go to WB.
      - Otherwise: go to RF.
  - WB:
    - Issues LINE_WORDS downstream WRITEs for the victim line, word 0 first.
    - Address = {victim tag, set, word, 3'b0}.
    - Each request is held stable with valid until ready.
    - The next request waits for operation_done (done may arrive ≥1 cycle after handshake).
    - After the last done, go to RF.
  - RF:
    - Issues LINE_WORDS downstream READs of the requested line, word 0 first, same protocol as WB.
    - Each done writes read_data into the victim way.
    - After the last word: tag written, valid=1, dirty=0, go to RESP.
  - RESP:
    - done=1 for one cycle; go to IDLE.
    - READ: read_data = selected word.
    - WRITE: word = (old & ~mask) | (data & mask), dirty=1; read_data=0.
- Latency: hit completes with done exactly 2 cycles after acceptance. A back-to-back request may be accepted the cycle after done.
- Multi-way hit cannot occur; if it does, the lowest way wins.
- A downstream done received when no request is outstanding is ignored.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_hit_cnt[31:0], perf_miss_cnt[31:0], perf_wb_cnt[31:0].
  - Counts are incremented in LOOKUP on hit, on miss, and on entering WB, respectively.
  - Counters wrap modulo 2^32 and are reset to 0.
  - Reserved-type requests are not counted.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Cold read 0x1000 with memory word = 0x1000 → 8 downstream READs 0x1000..0x1038; done with read_data at 0x1000's value; repeat read → done 2 cycles after accept, no downstream traffic.
- Write 0x1008 data 0xFFFF_FFFF_FFFF_FFFF, mask 0x0000_0000_FFFF_0000 to a resident line whose word is 0 → read 0x1008 returns 0x0000_0000_FFFF_0000.
- WAYS=2, SETS=16:
  - Dirty line at 0x1000, then reads 0x1000+0x400 and 0x1000+0x800 (same set) → second miss writes back 8 words 0x1000..0x1038 with the dirtied data, mask all ones, then refills.
- dcache2arb_tbus_index_ready held low 5 cycles during WB → index, data and type stable throughout; no extra requests.
- Assert reset during RF word 3 → downstream valid 0 immediately; after release, read 0x1000 misses and refills all 8 words.
- Type 2'b11 → done after 2 cycles, read_data 0, no downstream traffic, perf counters (if enabled) unchanged.
